// File: rtl/dmem_lsu.sv
// Word-organised data memory with RV32I load/store lane handling and a single-outstanding request/response handshake.
// A response appears READ_LAT cycles after acceptance and is held until rsp_ready; faulting accesses never touch the RAM.
module dmem_lsu #(
  parameter int DEPTH_WORDS = 256,
  parameter int READ_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] CNT_LAST = 2'((READ_LAT > 1) ? READ_LAT - 2 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [1:0]  cnt, cnt_nxt;
  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic [AW-1:0] idx;
  logic          range_err, funct_err, align_err, acc_err;
  logic [31:0]   rd_word, rd_shift, load_val, wr_data;
  logic [15:0]   half_val;
  logic [3:0]    be;

  assign accept = req_valid && (state == IDLE);
  assign idx    = req_addr[AW+1:2];

  assign range_err = {2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS);

  always_comb begin
    funct_err = 1'b0;
    case (req_funct3)
      3'b011, 3'b110, 3'b111: funct_err = 1'b1;
      3'b100, 3'b101:         funct_err = req_we; // unsigned variants exist only for loads
      default:                funct_err = 1'b0;
    endcase
  end

  assign align_err = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign acc_err   = range_err || funct_err || align_err;

  assign rd_word  = mem[idx];
  assign rd_shift = rd_word >> {req_addr[1:0], 3'b000};
  assign half_val = req_addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_val = rd_word;
    wr_data  = req_wdata;
    be       = 4'b0000;
    case (req_funct3[1:0])
      2'b00: begin
        load_val = {{24{~req_funct3[2] & rd_shift[7]}}, rd_shift[7:0]};
        wr_data  = {4{req_wdata[7:0]}};
        be       = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        load_val = {{16{~req_funct3[2] & half_val[15]}}, half_val};
        wr_data  = {2{req_wdata[15:0]}};
        be       = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        load_val = rd_word;
        wr_data  = req_wdata;
        be       = 4'b1111;
      end
      default: begin
        load_val = rd_word;
        wr_data  = req_wdata;
        be       = 4'b0000;
      end
    endcase
  end

  // RAM is deliberately left out of reset so stores survive a reset pulse.
  always_ff @(posedge clk) begin
    if (accept && req_we && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req_valid) begin
          cnt_nxt   = 2'd0;
          state_nxt = (READ_LAT == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt == CNT_LAST) state_nxt = RESP;
        else                 cnt_nxt   = cnt + 2'd1;
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        rsp_rdata <= (acc_err || req_we) ? 32'd0 : load_val;
        rsp_err   <= acc_err;
      end else if (state == RESP && rsp_ready) begin
        rsp_rdata <= 32'd0;
        rsp_err   <= 1'b0;
      end
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: directed RV32I load/store cases plus randomized traffic against a byte-lane memory model,
// on two instances (READ_LAT=1/DEPTH=256 and READ_LAT=3/DEPTH=16).
module tb_dmem_lsu;

  logic        clk;
  logic        rst_n      [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [2:0]  req_funct3 [2];
  logic        rsp_valid  [2];
  logic        rsp_ready  [2];
  logic [31:0] rsp_rdata  [2];
  logic        rsp_err    [2];

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mdl [2][256];

  dmem_lsu #(.DEPTH_WORDS(256), .READ_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_funct3(req_funct3[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

  dmem_lsu #(.DEPTH_WORDS(16), .READ_LAT(3)) u3 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_funct3(req_funct3[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic int depth_of(input int d);
    return (d == 0) ? 256 : 16;
  endfunction

  // Reference: applies the access to the model memory and returns the architectural response.
  function automatic void model_op(input int d, input bit we, input logic [31:0] a, input logic [31:0] wd,
                                   input logic [2:0] f3, output logic [31:0] er, output bit ee);
    int idx, off, nb, v;
    logic [31:0] w;
    idx = int'(a >> 2);
    off = int'(a & 32'd3);
    ee  = (idx >= depth_of(d)) || (f3 == 3) || (f3 == 6) || (f3 == 7) || (we && (f3 == 4 || f3 == 5)) ||
          ((f3 == 1 || f3 == 5) && (off % 2 != 0)) || (f3 == 2 && off != 0);
    er  = 32'd0;
    if (ee) return;
    w = mdl[d][idx];
    if (we) begin
      nb = (f3 == 0) ? 1 : (f3 == 1) ? 2 : 4;
      for (int k = 0; k < nb; k++) w[8*(off+k) +: 8] = wd[8*k +: 8];
      mdl[d][idx] = w;
    end else begin
      case (f3)
        3'd0, 3'd4: begin
          v = int'((w >> (8*off)) & 32'hFF);
          if (f3 == 0 && v > 127) v = v - 256;
        end
        3'd1, 3'd5: begin
          v = int'((w >> (8*off)) & 32'hFFFF);
          if (f3 == 1 && v > 32767) v = v - 65536;
        end
        default: v = int'(w);
      endcase
      er = 32'(v);
    end
  endfunction

  // Runs one transaction, optionally stalling rsp_ready, and reports what was observed plus model expectations.
  task automatic do_op(input int d, input bit we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] f3, input int stall,
                       output logic [31:0] got_rd, output logic got_err, output int lat,
                       output logic [31:0] exp_rd, output bit exp_err, output bit hold_ok);
    logic [31:0] h_rd;
    logic        h_err;
    @(negedge clk);
    hold_ok = (req_ready[d] === 1'b1);
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = a; req_wdata[d] = wd; req_funct3[d] = f3;
    rsp_ready[d] = 1'b1;
    model_op(d, we, a, wd, f3, exp_rd, exp_err);
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = 1'b0;
    req_we[d] = 1'($urandom); req_addr[d] = $urandom; req_wdata[d] = $urandom; req_funct3[d] = 3'($urandom);
    lat = 1;
    while (rsp_valid[d] !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (rsp_valid[d] !== 1'b1) begin
      lat = 99; got_rd = 'x; got_err = 'x; hold_ok = 1'b0;
      return;
    end
    got_rd = rsp_rdata[d]; got_err = rsp_err[d];
    h_rd = got_rd; h_err = got_err;
    if (stall > 0) rsp_ready[d] = 1'b0;
    repeat (stall) begin
      req_valid[d] = 1'b1; req_we[d] = 1'b0; req_addr[d] = 32'h4; req_funct3[d] = 3'd2;
      @(negedge clk);
      if (rsp_valid[d] !== 1'b1 || req_ready[d] !== 1'b0 || rsp_rdata[d] !== h_rd || rsp_err[d] !== h_err)
        hold_ok = 1'b0;
    end
    rsp_ready[d] = 1'b1;
    req_valid[d] = 1'($urandom);
    req_we[d] = 1'b0; req_addr[d] = 32'h4; req_funct3[d] = 3'd2;
    @(negedge clk);
    if (req_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0) hold_ok = 1'b0;
    req_valid[d] = 1'b0;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if ({req_ready[d], rsp_valid[d], rsp_err[d], rsp_rdata[d]} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
        n_fail++;
        $display("FAIL reset_state d%0d: got ready=%b valid=%b err=%b rdata=%h, want 1 0 0 00000000",
                 d, req_ready[d], rsp_valid[d], rsp_err[d], rsp_rdata[d]);
      end
    end
  endtask

  task automatic test_word();
    logic [31:0] rd, erd; logic err; bit eerr, hok; int lat;
    do_op(0, 1, 32'h10, 32'hDEADBEEF, 3'd2, 0, rd, err, lat, erd, eerr, hok);
    n_checks++;
    if ({err, rd} !== 33'd0) begin n_fail++; $display("FAIL sw_rsp: got err=%b rdata=%h, want 0 0", err, rd); end
    do_op(0, 0, 32'h10, 32'h0, 3'd2, 0, rd, err, lat, erd, eerr, hok);
    n_checks++;
    if ({err, rd} !== {1'b0, 32'hDEADBEEF}) begin n_fail++; $display("FAIL lw_data: got err=%b rdata=%h, want 0 deadbeef", err, rd); end
    n_checks++;
    if (lat !== 1 || hok !== 1'b1) begin n_fail++; $display("FAIL lw_latency: got lat=%0d hold=%b, want 1 1", lat, hok); end
  endtask

  task automatic test_byte();
    logic [31:0] rd, erd; logic err; bit eerr, hok; int lat;
    logic [2:0]  f3s  [3] = '{3'd0, 3'd4, 3'd2};
    logic [31:0] ads  [3] = '{32'h13, 32'h13, 32'h10};
    logic [31:0] want [3] = '{32'hFFFFFF80, 32'h00000080, 32'h80ADBEEF};
    do_op(0, 1, 32'h13, 32'h12345680, 3'd0, 0, rd, err, lat, erd, eerr, hok);
    for (int i = 0; i < 3; i++) begin
      do_op(0, 0, ads[i], 32'h0, f3s[i], 0, rd, err, lat, erd, eerr, hok);
      n_checks++;
      if ({err, rd} !== {1'b0, want[i]}) begin
        n_fail++; $display("FAIL byte_load%0d: got err=%b rdata=%h, want 0 %h", i, err, rd, want[i]);
      end
    end
  endtask

  task automatic test_half();
    logic [31:0] rd, erd; logic err; bit eerr, hok; int lat;
    logic [2:0]  f3s  [3] = '{3'd1, 3'd5, 3'd2};
    logic [31:0] ads  [3] = '{32'h22, 32'h22, 32'h20};
    logic [31:0] want [3] = '{32'hFFFF8001, 32'h00008001, 32'h80010000};
    do_op(0, 1, 32'h20, 32'h0, 3'd2, 0, rd, err, lat, erd, eerr, hok);
    do_op(0, 1, 32'h22, 32'h5A5A8001, 3'd1, 0, rd, err, lat, erd, eerr, hok);
    for (int i = 0; i < 3; i++) begin
      do_op(0, 0, ads[i], 32'h0, f3s[i], 0, rd, err, lat, erd, eerr, hok);
      n_checks++;
      if ({err, rd} !== {1'b0, want[i]}) begin
        n_fail++; $display("FAIL half_load%0d: got err=%b rdata=%h, want 0 %h", i, err, rd, want[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd, erd; logic err; bit eerr, hok; int lat;
    bit          wes [8] = '{0, 1, 0, 1, 0, 1, 1, 1};
    logic [31:0] ads [8] = '{32'h11, 32'h21, 32'h400, 32'h400, 32'h10, 32'h10, 32'h10, 32'h22};
    logic [2:0]  f3s [8] = '{3'd2, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd5};
    logic [31:0] chk [3] = '{32'h10, 32'h20, 32'h0};
    logic [31:0] cw  [3] = '{32'h80ADBEEF, 32'h80010000, 32'h12345678};
    do_op(0, 1, 32'h0, 32'h12345678, 3'd2, 0, rd, err, lat, erd, eerr, hok);
    for (int i = 0; i < 8; i++) begin
      do_op(0, wes[i], ads[i], 32'hFFFFFFFF, f3s[i], 0, rd, err, lat, erd, eerr, hok);
      n_checks++;
      if ({err, rd} !== {1'b1, 32'd0}) begin
        n_fail++; $display("FAIL err_case%0d: got err=%b rdata=%h, want 1 00000000", i, err, rd);
      end
    end
    for (int i = 0; i < 3; i++) begin
      do_op(0, 0, chk[i], 32'h0, 3'd2, 0, rd, err, lat, erd, eerr, hok);
      n_checks++;
      if ({err, rd} !== {1'b0, cw[i]}) begin
        n_fail++; $display("FAIL err_nowrite%0d: got err=%b rdata=%h, want 0 %h", i, err, rd, cw[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd, erd; logic err; bit eerr, hok; int lat;
    do_op(1, 1, 32'h4, 32'hCAFEF00D, 3'd2, 0, rd, err, lat, erd, eerr, hok);
    do_op(1, 0, 32'h6, 32'h0, 3'd1, 5, rd, err, lat, erd, eerr, hok);
    n_checks++;
    if ({err, rd} !== {1'b0, 32'hFFFFCAFE}) begin n_fail++; $display("FAIL bp_data: got err=%b rdata=%h, want 0 ffffcafe", err, rd); end
    n_checks++;
    if (lat !== 3) begin n_fail++; $display("FAIL bp_latency: got %0d, want 3", lat); end
    n_checks++;
    if (hok !== 1'b1) begin n_fail++; $display("FAIL bp_hold: outputs or req_ready moved during stall/handshake"); end
  endtask

  task automatic test_back_to_back();
    int t_rdy [$];
    int lim;
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'h4; req_funct3[1] = 3'd2; rsp_ready[1] = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (req_ready[1] === 1'b1) t_rdy.push_back(c);
      @(negedge clk);
    end
    req_valid[1] = 1'b0;
    lim = 0;
    while (req_ready[1] !== 1'b1 && lim < 20) begin @(negedge clk); lim++; end
    n_checks++;
    if (t_rdy.size() < 3 || t_rdy[1] - t_rdy[0] != 4 || t_rdy[2] - t_rdy[1] != 4) begin
      n_fail++; $display("FAIL b2b_spacing: got %0d accepts, first gaps wrong, want gap 4", t_rdy.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, erd; logic err; bit eerr, hok; int lat;
    logic [31:0] dummy; bit dummy_e;
    bit seen;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      req_valid[1] = 1'b1; req_we[1] = (i == 1); req_addr[1] = 32'h8;
      req_wdata[1] = 32'hA5A50FF0; req_funct3[1] = 3'd2; rsp_ready[1] = 1'b1;
      model_op(1, (i == 1), 32'h8, 32'hA5A50FF0, 3'd2, dummy, dummy_e);
      @(posedge clk);
      @(negedge clk);
      req_valid[1] = 1'b0;
      rst_n[1] = 1'b0;
      #1;
      n_checks++;
      if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1) begin
        n_fail++; $display("FAIL rst_mid%0d: got valid=%b ready=%b, want 0 1", i, rsp_valid[1], req_ready[1]);
      end
      @(negedge clk);
      rst_n[1] = 1'b1;
      seen = 1'b0;
      repeat (6) begin @(negedge clk); if (rsp_valid[1] !== 1'b0) seen = 1'b1; end
      n_checks++;
      if (seen) begin n_fail++; $display("FAIL rst_ghost%0d: got response after reset, want none", i); end
    end
    do_op(1, 0, 32'h8, 32'h0, 3'd2, 0, rd, err, lat, erd, eerr, hok);
    n_checks++;
    if ({err, rd} !== {1'b0, 32'hA5A50FF0}) begin n_fail++; $display("FAIL rst_store_kept: got %h, want a5a50ff0", rd); end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, a; logic err; bit eerr, hok, we; int lat, idx;
    logic [2:0] f3;
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 16; w++) begin
        do_op(d, 1, 32'(w * 4), $urandom, 3'd2, 0, rd, err, lat, erd, eerr, hok);
      end
      for (int n = 0; n < 120; n++) begin
        idx = $urandom_range(0, 19);
        if (idx >= 16) idx = depth_of(d) + idx - 16;
        a  = 32'(idx * 4) | 32'($urandom_range(0, 3));
        f3 = 3'($urandom_range(0, 7));
        we = 1'($urandom);
        do_op(d, we, a, $urandom, f3, $urandom_range(0, 3), rd, err, lat, erd, eerr, hok);
        n_checks++;
        if ({err, rd} !== {eerr, erd} || lat !== lat_of(d) || hok !== 1'b1) begin
          n_fail++;
          $display("FAIL rand d%0d we=%b a=%h f3=%0d: got err=%b rdata=%h lat=%0d hold=%b, want %b %h %0d 1",
                   d, we, a, f3, err, rd, lat, hok, eerr, erd, lat_of(d));
        end
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
      req_wdata[d] = '0; req_funct3[d] = '0; rsp_ready[d] = 1'b1;
    end
    repeat (3) @(negedge clk);
    test_reset();
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(negedge clk);
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
